// File: rtl/image_frame_ram.sv
// image_frame_ram: 2D pixel store with raster-order streaming load, random (x,y) write/read, busy status.
// Optional clear-fill state is built when IMG_FRAME_RAM_CLEAR_EN is defined.
module image_frame_ram #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH_X      = 300,
  parameter int DEPTH_Y      = 300,
  parameter int ADDR_WIDTH_X = $clog2(DEPTH_X),
  parameter int ADDR_WIDTH_Y = $clog2(DEPTH_Y)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_start,
  input  logic                    ld_valid,
  input  logic [DATA_WIDTH-1:0]   ld_data,
  output logic                    ld_ready,
  output logic                    load_done,
  output logic                    busy,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH_X-1:0] wr_x,
  input  logic [ADDR_WIDTH_Y-1:0] wr_y,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH_X-1:0] rd_x,
  input  logic [ADDR_WIDTH_Y-1:0] rd_y,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    rd_err,
  input  logic                    clr_start,
  input  logic [DATA_WIDTH-1:0]   clr_val
);

  localparam logic [ADDR_WIDTH_X-1:0] X_LAST = ADDR_WIDTH_X'(DEPTH_X - 1);
  localparam logic [ADDR_WIDTH_Y-1:0] Y_LAST = ADDR_WIDTH_Y'(DEPTH_Y - 1);
  localparam logic [ADDR_WIDTH_X:0]   X_LIM  = (ADDR_WIDTH_X + 1)'(DEPTH_X);
  localparam logic [ADDR_WIDTH_Y:0]   Y_LIM  = (ADDR_WIDTH_Y + 1)'(DEPTH_Y);

`ifdef IMG_FRAME_RAM_CLEAR_EN
  typedef enum logic [1:0] {IDLE, LOAD, CLEAR} state_t;
  logic [DATA_WIDTH-1:0] clr_val_q;
`else
  typedef enum logic [1:0] {IDLE, LOAD} state_t;
  logic unused_clr;
  assign unused_clr = ^{clr_start, clr_val};
`endif

  state_t                  state;
  logic [ADDR_WIDTH_X-1:0] x_cnt;
  logic [ADDR_WIDTH_Y-1:0] y_cnt;
  logic                    last_pix;
  logic                    adv;
  logic                    wr_in_range;
  logic                    rd_in_range;

  logic                    mem_we;
  logic [ADDR_WIDTH_X-1:0] mem_wx;
  logic [ADDR_WIDTH_Y-1:0] mem_wy;
  logic [DATA_WIDTH-1:0]   mem_wd;
  logic [DATA_WIDTH-1:0]   mem [DEPTH_Y][DEPTH_X];

  assign ld_ready    = (state == LOAD);
  assign busy        = (state != IDLE);
  assign last_pix    = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
  assign wr_in_range = ({1'b0, wr_x} < X_LIM) && ({1'b0, wr_y} < Y_LIM);
  assign rd_in_range = ({1'b0, rd_x} < X_LIM) && ({1'b0, rd_y} < Y_LIM);

`ifdef IMG_FRAME_RAM_CLEAR_EN
  assign adv = (state == CLEAR) || (state == LOAD && ld_valid);
`else
  assign adv = (state == LOAD) && ld_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_cnt     <= '0;
      y_cnt     <= '0;
      load_done <= 1'b0;
`ifdef IMG_FRAME_RAM_CLEAR_EN
      clr_val_q <= '0;
`endif
    end else begin
      load_done <= 1'b0;
      if (state == IDLE) begin
        x_cnt <= '0;
        y_cnt <= '0;
        if (load_start) begin
          state <= LOAD;
`ifdef IMG_FRAME_RAM_CLEAR_EN
        end else if (clr_start) begin
          state     <= CLEAR;
          clr_val_q <= clr_val;
`endif
        end
      end else if (adv) begin
        // Raster walk shared by load and clear; the last pixel rewinds to origin.
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= last_pix ? '0 : y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
        if (last_pix) begin
          load_done <= (state == LOAD);
          state     <= IDLE;
        end
      end
    end
  end

  always_comb begin
    mem_we = 1'b0;
    mem_wx = wr_x;
    mem_wy = wr_y;
    mem_wd = wr_data;
    case (state)
      IDLE: mem_we = wr_en && wr_in_range;
      LOAD: begin
        mem_we = ld_valid;
        mem_wx = x_cnt;
        mem_wy = y_cnt;
        mem_wd = ld_data;
      end
`ifdef IMG_FRAME_RAM_CLEAR_EN
      CLEAR: begin
        mem_we = 1'b1;
        mem_wx = x_cnt;
        mem_wy = y_cnt;
        mem_wd = clr_val_q;
      end
`endif
      default: mem_we = 1'b0;
    endcase
  end

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wy][mem_wx] <= mem_wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en && !rd_in_range;
      if (rd_en) rd_data <= rd_in_range ? mem[rd_y][rd_x] : '0;
    end
  end

endmodule

// File: tb/tb_image_frame_ram.sv
// Bench for image_frame_ram (5x3 frame): random stimulus vs. raster-index frame model, read scoreboard.
module tb_image_frame_ram;
  localparam int NX = 5;
  localparam int NY = 3;
  localparam int NP = NX * NY;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_start = 1'b0, ld_valid = 1'b0, ld_ready, load_done, busy;
  logic [7:0] ld_data = '0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_x = '0;
  logic [1:0] wr_y = '0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [2:0] rd_x = '0;
  logic [1:0] rd_y = '0;
  logic [7:0] rd_data;
  logic       rd_valid, rd_err;
  logic       clr_start = 1'b0;
  logic [7:0] clr_val = '0;

  image_frame_ram #(.DATA_WIDTH(8), .DEPTH_X(NX), .DEPTH_Y(NY)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .load_done(load_done), .busy(busy), .wr_en(wr_en), .wr_x(wr_x),
    .wr_y(wr_y), .wr_data(wr_data), .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_err(rd_err), .clr_start(clr_start), .clr_val(clr_val)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  logic [7:0] model [NP];
  bit         m_load = 0, m_clear = 0;
  int         m_pos = 0;
  logic [7:0] m_clr = '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: linear raster index y*NX+x; reads see the frame before this cycle's write.
  task automatic cycle();
    bit exp_done;
    exp_done = 0;
    if (rd_en) begin
      if (int'(rd_x) < NX && int'(rd_y) < NY) exp_q.push_back({1'b0, model[int'(rd_y) * NX + int'(rd_x)]});
      else exp_q.push_back(9'h100);
    end
    if (m_load) begin
      if (ld_valid) begin
        model[m_pos] = ld_data;
        m_pos++;
        if (m_pos == NP) begin m_load = 0; m_pos = 0; exp_done = 1; end
      end
    end else if (m_clear) begin
      model[m_pos] = m_clr;
      m_pos++;
      if (m_pos == NP) begin m_clear = 0; m_pos = 0; end
    end else begin
      if (wr_en && int'(wr_x) < NX && int'(wr_y) < NY) model[int'(wr_y) * NX + int'(wr_x)] = wr_data;
      if (load_start) begin m_load = 1; m_pos = 0; end
`ifdef IMG_FRAME_RAM_CLEAR_EN
      else if (clr_start) begin m_clear = 1; m_pos = 0; m_clr = clr_val; end
`endif
    end
    @(posedge clk); #1;
    check("load_done", load_done, exp_done);
    check("busy", busy, m_load | m_clear);
    check("ld_ready", ld_ready, m_load);
  endtask

  task automatic idle_inputs();
    load_start = 0; ld_valid = 0; wr_en = 0; rd_en = 0; clr_start = 0;
  endtask

  task automatic rand_read();
    rd_en = 1'($urandom_range(1));
    rd_x  = 3'($urandom_range(7));
    rd_y  = 2'($urandom_range(3));
  endtask

  task automatic read_all();
    idle_inputs();
    for (int y = 0; y < NY; y++)
      for (int x = 0; x < NX; x++) begin
        rd_en = 1; rd_x = 3'(x); rd_y = 2'(y); cycle();
      end
    rd_x = 3'd5; rd_y = 2'd0; cycle();
    rd_x = 3'd0; rd_y = 2'd3; cycle();
    idle_inputs();
  endtask

  // rnd=0: pixel value = raster index, ld_valid toggles; rnd=1: random data, valid, writes, restarts.
  task automatic do_load(input bit rnd, input int stop_at);
    int guard;
    guard = 0;
    load_start = 1; cycle(); load_start = 0; clr_start = 0; wr_en = 0;
    while (m_load && m_pos < stop_at && guard < 200) begin
      ld_valid   = rnd ? 1'($urandom_range(1)) : 1'(guard % 2 == 0);
      ld_data    = rnd ? 8'($urandom) : 8'(m_pos);
      wr_en      = rnd ? 1'($urandom_range(1)) : 1'b0;
      wr_x = 3'd1; wr_y = 2'd1; wr_data = 8'h77;
      load_start = rnd ? 1'($urandom_range(1)) : 1'b0;
      rand_read();
      cycle();
      guard++;
    end
    check("load_within_budget", int'(guard < 200), 1);
    idle_inputs();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("rd_data", rd_data, mon_e[7:0]);
          check("rd_err", rd_err, mon_e[8]);
        end
      end else check("rd_err_without_valid", rd_err, 0);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_load_done", load_done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_err", rd_err, 0);
    check("rst_rd_data", rd_data, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // Frame 0..14 with toggling valid; (4,2)=14 and (0,1)=5 fall out of the full scan.
    do_load(0, NP);
    read_all();

    // Random write with same-cycle read (old data), then read-back.
    wr_en = 1; wr_x = 3'd2; wr_y = 2'd1; wr_data = 8'hAA;
    rd_en = 1; rd_x = 3'd2; rd_y = 2'd1; cycle();
    wr_en = 0; cycle();
    idle_inputs();

    // Out-of-range reads and a dropped out-of-range write.
    rd_en = 1; rd_x = 3'd5; rd_y = 2'd0; cycle();
    rd_x = 3'd0; rd_y = 2'd3; cycle();
    rd_en = 0; wr_en = 1; wr_x = 3'd5; wr_y = 2'd0; wr_data = 8'h55; cycle();
    read_all();

    // Write and load_start in the same idle cycle, then writes/restarts ignored during load.
    wr_en = 1; wr_x = 3'd3; wr_y = 2'd0; wr_data = 8'h99;
    do_load(1, NP);
    read_all();

    // Reset mid-load after 7 pixels, then a fresh load from the origin.
    do_load(1, 7);
    rst_n = 0; #1;
    check("abort_busy", busy, 0);
    check("abort_ld_ready", ld_ready, 0);
    check("abort_load_done", load_done, 0);
    check("abort_rd_valid", rd_valid, 0);
    exp_q.delete();
    m_load = 0; m_pos = 0;
    @(posedge clk); #1;
    check("abort_no_done", load_done, 0);
    rst_n = 1;
    @(posedge clk); #1;
    read_all();
    do_load(1, NP);
    read_all();

    // Clear fill (inert without the feature), with writes/restarts attempted while busy.
    clr_val = 8'h3C; clr_start = 1; cycle(); clr_start = 0;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'($urandom_range(1)); wr_x = 3'($urandom_range(4)); wr_y = 2'($urandom_range(2));
      wr_data = 8'($urandom);
      load_start = m_clear ? 1'($urandom_range(1)) : 1'b0;
      rand_read();
      cycle();
    end
    read_all();

    // load_start wins over clr_start.
    clr_start = 1; clr_val = 8'hE1;
    do_load(1, NP);
    read_all();

    for (int i = 0; i < 40; i++) begin
      wr_en = 1'($urandom_range(1)); wr_x = 3'($urandom_range(7)); wr_y = 2'($urandom_range(3));
      wr_data = 8'($urandom);
      rand_read();
      cycle();
    end
    read_all();
    cycle(); cycle();
    check("rd_lost", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
